pic_eeprom: RTL

Data-EEPROM backing store for the PIC16F84-class core. It services the core's EEPROM read/write request-acknowledge handshake on eepadr/eepdtout/eepdtin. It replaces the tie-offs (existeeprom=0, acks=1) at the top level: the top drives existeeprom=1 and wires this block's acks back to the core. The block holds a 2^ADDR_W x 8 array and models the self-timed write delay of a real EEPROM cell.

---
 rtl/pic_eeprom_if.sv | 34 +++
 rtl/pic_eeprom.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pic_eeprom_if.sv
// Core <-> data-EEPROM request/acknowledge bus. Defining EEP_IRQ_EN adds the
// EEIF write-complete flag and its clear input.
interface pic_eeprom_if;
  logic [7:0] eepadr;
  logic [7:0] eepdtout;
  logic [7:0] eepdtin;
  logic       readeepreq;
  logic       readeepack;
  logic       writeeepreq;
  logic       writeeepack;
  logic       busy;
`ifdef EEP_IRQ_EN
  logic       eeif_clr;
  logic       eeif;

  modport master (
    output eepadr, eepdtout, readeepreq, writeeepreq, eeif_clr,
    input  eepdtin, readeepack, writeeepack, busy, eeif
  );
  modport slave (
    input  eepadr, eepdtout, readeepreq, writeeepreq, eeif_clr,
    output eepdtin, readeepack, writeeepack, busy, eeif
  );
`else
  modport master (
    output eepadr, eepdtout, readeepreq, writeeepreq,
    input  eepdtin, readeepack, writeeepack, busy
  );
  modport slave (
    input  eepadr, eepdtout, readeepreq, writeeepreq,
    output eepdtin, readeepack, writeeepack, busy
  );
`endif
endinterface

// File: rtl/pic_eeprom.sv
// Data-EEPROM backing store for a PIC16F84-class core with a self-timed write.
// Optional EEIF write-complete flag is enabled by defining EEP_IRQ_EN.
module pic_eeprom #(
  parameter int ADDR_W    = 6,
  parameter int WR_CYCLES = 16
) (
  input  logic         clkin,
  input  logic         reset,
  pic_eeprom_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD, WR, ACK, WAITLOW} state_t;

  localparam int DEPTH = 1 << ADDR_W;
  // The latch cycle counts as part of the write time, so the counter runs
  // WR_CYCLES+1 edges from request latch to commit.
  localparam logic [15:0] WR_LOAD = 16'(WR_CYCLES);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [7:0]         data_q, data_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               rd_phase_q, rd_phase_d;
  logic               op_wr_q, op_wr_d;
  logic [7:0]         eepdtin_q, eepdtin_d;
  logic               rdack_q, rdack_d;
  logic               wrack_q, wrack_d;
  logic               mem_we;

  logic [7:0]         mem [0:DEPTH-1];
  logic [7:0]         ram_rd_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rd_phase_d = 1'b0;
    op_wr_d    = op_wr_q;
    eepdtin_d  = eepdtin_q;
    rdack_d    = 1'b0;
    wrack_d    = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.writeeepreq) begin
          addr_d  = bus.eepadr[ADDR_W-1:0];
          data_d  = bus.eepdtout;
          cnt_d   = WR_LOAD;
          op_wr_d = 1'b1;
          state_d = WR;
        end else if (bus.readeepreq) begin
          addr_d  = bus.eepadr[ADDR_W-1:0];
          op_wr_d = 1'b0;
          state_d = RD;
        end
      end
      RD: begin
        // First edge loads the RAM output register, second presents it.
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          eepdtin_d = ram_rd_q;
          rdack_d   = 1'b1;
          state_d   = ACK;
        end
      end
      WR: begin
        if (cnt_q == 16'd0) begin
          mem_we  = 1'b1;
          wrack_d = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ACK: state_d = WAITLOW;
      WAITLOW: begin
        // Only the serviced request must drop; a pending read behind a
        // write is then picked up from IDLE.
        if (op_wr_q ? !bus.writeeepreq : !bus.readeepreq)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= 8'h00;
      cnt_q      <= 16'd0;
      rd_phase_q <= 1'b0;
      op_wr_q    <= 1'b0;
      eepdtin_q  <= 8'h00;
      rdack_q    <= 1'b0;
      wrack_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rd_phase_q <= rd_phase_d;
      op_wr_q    <= op_wr_d;
      eepdtin_q  <= eepdtin_d;
      rdack_q    <= rdack_d;
      wrack_q    <= wrack_d;
    end
  end

  // Storage is deliberately outside the reset domain so it maps to block RAM.
  always_ff @(posedge clkin) begin
    if (mem_we)
      mem[addr_q] <= data_q;
    ram_rd_q <= mem[addr_q];
  end

  assign bus.eepdtin     = eepdtin_q;
  assign bus.readeepack  = rdack_q;
  assign bus.writeeepack = wrack_q;
  assign bus.busy        = (state_q != IDLE);

`ifdef EEP_IRQ_EN
  logic eeif_q, eeif_d;

  always_comb begin
    eeif_d = eeif_q;
    if (wrack_d)
      eeif_d = 1'b1;
    else if (bus.eeif_clr)
      eeif_d = 1'b0;
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset)
      eeif_q <= 1'b0;
    else
      eeif_q <= eeif_d;
  end

  assign bus.eeif = eeif_q;
`endif

  generate
    if (ADDR_W < 8) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.eepadr[7:ADDR_W];
    end
  endgenerate

endmodule
